clkdiv_prog: RTL and testbench

//  Programmable, glitch-free integer clock divider. Generates the CLK_IN feed for twophase_nonoverlap from the system clock.

---
 rtl/clkdiv_pkg.sv | 26 ++
 rtl/clkdiv_ratio_reg.sv | 59 +++++
 rtl/clkdiv_prog.sv | 132 +++++++++++++
 tb/tb_clkdiv_prog.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// split_ratio() maps a divide ratio N onto the (H-1, L-1) counter reload values.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  typedef struct packed {
    logic [31:0] hm1;
    logic [31:0] lm1;
  } split_t;

  // Odd ratios put the extra cycle in the high phase: H = N - N/2, L = N/2.
  function automatic split_t split_ratio(input logic [31:0] n);
    split_t s;
    s.lm1 = (n >> 1) - 32'd1;
    s.hm1 = n - (n >> 1) - 32'd1;
    return s;
  endfunction

endpackage

// File: rtl/clkdiv_ratio_reg.sv
// Pending/active divide-ratio registers with clamp, pending flag and DIV_ACK.
// A load on the same edge as a boundary is kept pending for the following boundary.
module clkdiv_ratio_reg
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_val,
  input  logic             i_boundary,
  output logic [DIV_W-1:0] o_hm1_bnd,
  output logic [DIV_W-1:0] o_lm1,
  output logic             o_ack
);

  logic [DIV_W-1:0] r_pend;
  logic [DIV_W-1:0] r_hm1;
  logic [DIV_W-1:0] r_lm1;
  logic             r_flag;
  logic             r_ack;
  logic [DIV_W-1:0] w_clamped;
  split_t           w_pend_split;
  split_t           w_def_split;

  assign w_clamped    = (i_val < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_val;
  assign w_pend_split = split_ratio(32'(r_pend));
  assign w_def_split  = split_ratio(32'(DIV_DEFAULT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= DIV_W'(DIV_DEFAULT);
      r_hm1  <= DIV_W'(w_def_split.hm1);
      r_lm1  <= DIV_W'(w_def_split.lm1);
      r_flag <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= i_boundary & r_flag;
      if (i_boundary && r_flag) begin
        r_hm1 <= DIV_W'(w_pend_split.hm1);
        r_lm1 <= DIV_W'(w_pend_split.lm1);
      end
      if (i_load) begin
        r_pend <= w_clamped;
        r_flag <= 1'b1;
      end else if (i_boundary) begin
        r_flag <= 1'b0;
      end
    end
  end

  // The boundary edge must already load the counter with the incoming ratio.
  assign o_hm1_bnd = r_flag ? DIV_W'(w_pend_split.hm1) : r_hm1;
  assign o_lm1     = r_lm1;
  assign o_ack     = r_ack;

endmodule

// File: rtl/clkdiv_prog.sv
// Programmable glitch-free integer clock divider with run/stop, ratio reload
// at period boundaries, phase re-align and registered edge strobes.
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIV_LOAD,
  input  logic [DIV_W-1:0] DIV_VAL,
  input  logic             SYNC_IN,
  output logic             CLK_DIV,
  output logic             RISE_STB,
  output logic             FALL_STB,
  output logic             DIV_ACK,
  output logic             RUNNING
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             r_clk;
  logic             w_clk_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;
  logic             r_running;
  logic             w_bnd;
  logic             w_restart;
  logic [DIV_W-1:0] w_hm1_bnd;
  logic [DIV_W-1:0] w_lm1;
  logic             w_ack;

  clkdiv_ratio_reg #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_ratio (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (DIV_LOAD),
    .i_val      (DIV_VAL),
    .i_boundary (w_bnd),
    .o_hm1_bnd  (w_hm1_bnd),
    .o_lm1      (w_lm1),
    .o_ack      (w_ack)
  );

  // SYNC_IN only restarts while running and EN is held; with EN low the stop wins.
  assign w_restart = SYNC_IN & EN;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - 1'b1;
    w_clk_nxt   = r_clk;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_bnd       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (EN) begin
          w_bnd       = 1'b1;
          w_state_nxt = ST_HIGH;
          w_clk_nxt   = 1'b1;
          w_rise_nxt  = 1'b1;
          w_cnt_nxt   = w_hm1_bnd;
        end
      end
      ST_HIGH: begin
        if (w_restart) begin
          w_bnd     = 1'b1;
          w_cnt_nxt = w_hm1_bnd;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_LOW;
          w_clk_nxt   = 1'b0;
          w_fall_nxt  = 1'b1;
          w_cnt_nxt   = w_lm1;
        end
      end
      ST_LOW: begin
        if ((r_cnt == '0) || w_restart) begin
          w_bnd = 1'b1;
          if (EN) begin
            w_state_nxt = ST_HIGH;
            w_clk_nxt   = 1'b1;
            w_rise_nxt  = 1'b1;
            w_cnt_nxt   = w_hm1_bnd;
          end else begin
            w_state_nxt = ST_IDLE;
            w_clk_nxt   = 1'b0;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_clk_nxt   = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_clk     <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clk     <= w_clk_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_running <= (w_state_nxt != ST_IDLE);
    end
  end

  assign CLK_DIV  = r_clk;
  assign RISE_STB = r_rise;
  assign FALL_STB = r_fall;
  assign DIV_ACK  = w_ack;
  assign RUNNING  = r_running;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Self-checking bench for clkdiv_prog: a reset/start vector table, directed
// corner sequences and a random burst, all checked through an expected-output queue.
module tb_clkdiv_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] val = '0;
  logic       sync = 1'b0;
  logic       clk_div, rise, fall, ack, running;

  always #5 clk = ~clk;

  clkdiv_prog #(.DIV_W(8), .DIV_DEFAULT(4)) dut (
    .CLK(clk), .RST(rst), .EN(en), .DIV_LOAD(load), .DIV_VAL(val), .SYNC_IN(sync),
    .CLK_DIV(clk_div), .RISE_STB(rise), .FALL_STB(fall), .DIV_ACK(ack), .RUNNING(running)
  );

  int n_checks = 0;
  int n_fail   = 0;
  string tag = "init";
  logic [4:0] exp_q[$];

  // Reference model: position within the period, high while pos < H.
  int m_N = 4, m_pend = 4, m_pos = 0;
  bit m_flag = 0, m_run = 0, m_clk = 0, m_rise = 0, m_fall = 0, m_ack = 0;

  function automatic int hi_of(input int n);
    return n - n / 2;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit l, input int v, input bit s);
    bit old_clk, bnd;
    old_clk = m_clk; m_rise = 0; m_fall = 0; m_ack = 0;
    if (r) begin
      m_N = 4; m_pend = 4; m_flag = 0; m_run = 0; m_pos = 0; m_clk = 0;
      return;
    end
    if (!m_run) bnd = e;
    else        bnd = (m_pos == m_N - 1) || (s && e);
    if (bnd) begin
      if (m_flag) begin m_N = m_pend; m_flag = 0; m_ack = 1; end
      if (e) begin m_run = 1; m_pos = 0; m_clk = 1; m_rise = !old_clk; end
      else   begin m_run = 0; m_pos = 0; m_clk = 0; end
    end else if (m_run) begin
      m_pos++;
      m_clk  = (m_pos < hi_of(m_N));
      m_fall = old_clk && !m_clk;
    end
    if (l) begin m_pend = (v < 2) ? 2 : v; m_flag = 1; end
  endtask

  // Run-length tracking for the minimum-pulse-width check.
  logic prev_clk = 1'b0;
  int   run_len = 0, run_req = 0, last_hi = 0, last_lo = 0;
  bit   excuse = 1, cur_ev = 0;

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  task automatic sample();
    logic [4:0] got, e;
    @(posedge clk);
    #1;
    got = {clk_div, rise, fall, ack, running};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: {clk,rise,fall,ack,run} got %b expected %b at %0t", tag, got, e, $time);
    end
    if (clk_div === prev_clk) begin
      run_len++;
      excuse |= cur_ev;
    end else begin
      if (!excuse && !cur_ev) chk({"min_run_", prev_clk ? "high" : "low"}, (run_len >= run_req) ? 1 : 0, 1);
      if (prev_clk) last_hi = run_len; else last_lo = run_len;
      prev_clk = clk_div;
      run_len  = 1;
      excuse   = cur_ev;
      run_req  = clk_div ? hi_of(m_N) : m_N / 2;
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit l, input int v, input bit s);
    rst = r; en = e; load = l; val = 8'(v); sync = s; cur_ev = r | s;
    model_step(r, e, l, v, s);
    exp_q.push_back({m_clk, m_rise, m_fall, m_ack, m_run});
    sample();
  endtask

  task automatic run_until_ack(input string name);
    int i;
    for (i = 0; i < 40 && !m_ack; i++) cyc(0, 1, 0, 0, 0);
    chk({name, "_ack_timeout"}, m_ack ? 1 : 0, 1);
  endtask

  task automatic run_until_pos(input string name, input int p);
    int i;
    for (i = 0; i < 40 && !(m_run && m_pos == p); i++) cyc(0, 1, 0, 0, 0);
    chk({name, "_pos_timeout"}, (m_run && m_pos == p) ? 1 : 0, 1);
  endtask

  typedef struct {
    bit         rst, en, load;
    int         v;
    bit         sync;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {clk,rise,fall,ack,run}: two reset cycles, then EN held at ratio 4.
    tbl[0] = '{1, 0, 0, 0, 0, 5'b00000};
    tbl[1] = '{1, 0, 0, 0, 0, 5'b00000};
    tbl[2] = '{0, 1, 0, 0, 0, 5'b11001};
    tbl[3] = '{0, 1, 0, 0, 0, 5'b10001};
    tbl[4] = '{0, 1, 0, 0, 0, 5'b00101};
    tbl[5] = '{0, 1, 0, 0, 0, 5'b00001};
    tbl[6] = '{0, 1, 0, 0, 0, 5'b11001};
    tbl[7] = '{0, 1, 0, 0, 0, 5'b10001};
    tbl[8] = '{0, 1, 0, 0, 0, 5'b00101};
    tbl[9] = '{0, 1, 0, 0, 0, 5'b00001};

    tag = "t1_table";
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; load = tbl[i].load; val = 8'(tbl[i].v);
      sync = tbl[i].sync; cur_ev = tbl[i].rst | tbl[i].sync;
      model_step(tbl[i].rst, tbl[i].en, tbl[i].load, tbl[i].v, tbl[i].sync);
      exp_q.push_back(tbl[i].exp);
      sample();
    end

    tag = "t2_reload5";
    run_until_pos("t2", 0);
    cyc(0, 1, 1, 5, 0);
    run_until_ack("t2");
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0);
    chk("t2_high_len", last_hi, 3);
    chk("t2_low_len", last_lo, 2);

    tag = "t3_clamp";
    cyc(0, 1, 1, 0, 0);
    run_until_ack("t3a");
    cyc(0, 1, 1, 1, 0);
    run_until_ack("t3b");
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
    chk("t3_high_len", last_hi, 1);
    chk("t3_low_len", last_lo, 1);
    run_until_pos("t3", 1);
    cyc(0, 1, 1, 6, 0);
    chk("t3_boundary_load_deferred", m_ack ? 1 : 0, 0);
    run_until_ack("t3c");

    tag = "t4_stop";
    for (int i = 0; i < 40 && !m_rise; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    chk("t4_high_len", last_hi, 3);
    chk("t4_idle", m_run ? 1 : 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0);
    chk("t4_no_gap_low_len", last_lo, 3);

    tag = "t5_sync";
    cyc(0, 1, 1, 8, 0);
    run_until_ack("t5");
    run_until_pos("t5", 5);
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
    chk("t5_high_len", last_hi, 4);
    run_until_pos("t5h", 1);
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

    tag = "t6_reset";
    cyc(0, 0, 1, 5, 0);
    cyc(0, 1, 0, 0, 0);
    chk("t6_ack_on_start", m_ack ? 1 : 0, 1);
    cyc(0, 1, 1, 7, 0);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
    chk("t6_high_len", last_hi, 2);
    chk("t6_low_len", last_lo, 2);

    tag = "random";
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
          int'($urandom_range(0, 9)), ($urandom_range(0, 14) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
